// File: rtl/window_addr_gen_if.sv
// Strobe, configuration and result bundle between the convolution controller
// (master) and the window counter/address stage (slave).
interface window_addr_gen_if #(
    parameter int CNT_W  = 8,
    parameter int JOB_W  = 12,
    parameter int ADDR_W = 16
);
    logic              clrW;
    logic              clr0;
    logic              clr1;
    logic              clr2;
    logic              en0;
    logic              en1;
    logic              en2;
    logic              ld;
    logic [CNT_W-1:0]  cfg_lim0;
    logic [CNT_W-1:0]  cfg_lim1;
    logic [CNT_W-1:0]  cfg_lim2;
    logic [JOB_W-1:0]  cfg_jobs;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_row;
    logic [ADDR_W-1:0] cfg_stride;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;
    logic              ov0;
    logic              ov1;
    logic              ov2;
    logic              ov;
    logic [ADDR_W-1:0] rd_addr;

    modport master (
        output clrW, clr0, clr1, clr2, en0, en1, en2, ld,
        output cfg_lim0, cfg_lim1, cfg_lim2, cfg_jobs, cfg_base, cfg_row, cfg_stride,
        input  cnt0, cnt1, cnt2, ov0, ov1, ov2, ov, rd_addr
    );

    modport slave (
        input  clrW, clr0, clr1, clr2, en0, en1, en2, ld,
        input  cfg_lim0, cfg_lim1, cfg_lim2, cfg_jobs, cfg_base, cfg_row, cfg_stride,
        output cnt0, cnt1, cnt2, ov0, ov1, ov2, ov, rd_addr
    );
endinterface

// File: rtl/window_addr_gen.sv
// Three independent wrap counters, window base / job counter and the
// input-buffer read address for the convolution datapath.
module window_addr_gen #(
    parameter int CNT_W  = 8,
    parameter int JOB_W  = 12,
    parameter int ADDR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    window_addr_gen_if.slave bus
);
    logic [2:0]            clr_vec;
    logic [2:0]            en_vec;
    logic [2:0]            ov_vec;
    logic [2:0][CNT_W-1:0] lim_in;
    logic [2:0][CNT_W-1:0] cnt_vec;

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] row_reg;
    logic [ADDR_W-1:0] stride_reg;
    logic [ADDR_W-1:0] win_base_reg;
    logic [ADDR_W-1:0] win_base_next;
    logic [JOB_W-1:0]  jobs_reg;
    logic [JOB_W-1:0]  jcnt_reg;
    logic [JOB_W-1:0]  jcnt_next;
    logic              ov_reg;
    logic              armed_reg;
    logic              ld_ok;

    assign clr_vec = {bus.clr2, bus.clr1, bus.clr0};
    assign en_vec  = {bus.en2, bus.en1, bus.en0};
    assign lim_in  = {bus.cfg_lim2, bus.cfg_lim1, bus.cfg_lim0};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] lim_reg;
            logic [CNT_W-1:0] last_val;

            // A zero limit behaves as a limit of one: the counter parks at 0.
            assign last_val     = (lim_reg == '0) ? '0 : lim_reg - 1'b1;
            assign ov_vec[gi]   = (cnt_reg == last_val);
            assign cnt_vec[gi]  = cnt_reg;

            always_comb begin
                cnt_next = cnt_reg;
                if (bus.clrW || clr_vec[gi]) begin
                    cnt_next = '0;
                end else if (en_vec[gi]) begin
                    cnt_next = ov_vec[gi] ? '0 : cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                    lim_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                    if (bus.clrW) begin
                        lim_reg <= lim_in[gi];
                    end
                end
            end
        end
    endgenerate

    // ld only counts while a job started by clrW is still short of its window count.
    assign ld_ok         = bus.ld && armed_reg && !ov_reg && (jcnt_reg != jobs_reg);
    assign jcnt_next     = ld_ok ? jcnt_reg + 1'b1 : jcnt_reg;
    assign win_base_next = ld_ok ? win_base_reg + stride_reg : win_base_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg     <= '0;
            row_reg      <= '0;
            stride_reg   <= '0;
            jobs_reg     <= '0;
            win_base_reg <= '0;
            jcnt_reg     <= '0;
            ov_reg       <= 1'b0;
            armed_reg    <= 1'b0;
        end else if (bus.clrW) begin
            base_reg     <= bus.cfg_base;
            row_reg      <= bus.cfg_row;
            stride_reg   <= bus.cfg_stride;
            jobs_reg     <= bus.cfg_jobs;
            win_base_reg <= '0;
            jcnt_reg     <= '0;
            ov_reg       <= 1'b0;
            armed_reg    <= 1'b1;
        end else begin
            win_base_reg <= win_base_next;
            jcnt_reg     <= jcnt_next;
            ov_reg       <= ov_reg | (armed_reg && (jcnt_next == jobs_reg));
        end
    end

    assign bus.cnt0    = cnt_vec[0];
    assign bus.cnt1    = cnt_vec[1];
    assign bus.cnt2    = cnt_vec[2];
    assign bus.ov0     = ov_vec[0];
    assign bus.ov1     = ov_vec[1];
    assign bus.ov2     = ov_vec[2];
    assign bus.ov      = ov_reg;
    // cnt0 indexes the filter memory externally and stays out of the address.
    assign bus.rd_addr = base_reg + win_base_reg
                       + ADDR_W'(cnt_vec[1]) * row_reg
                       + ADDR_W'(cnt_vec[2]);
endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
- Counter/address stage that sits directly downstream of the convolution controller.
- Consumes the controller's clear/enable/load strobes (clrW, clr0..2, en0..2, ld).
- Produces the counter-overflow flags ov0/ov1/ov2, the job-done flag ov, and the read address for the input buffer.
- Holds the per-job configuration, which is latched at init.

Parameters:
CNT_W, 8, width of cnt0/cnt1/cnt2 and their limits
JOB_W, 12, width of the window (job) counter
ADDR_W, 16, read-address width; all address arithmetic is modulo 2^ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clrW  in  1  init strobe: latch cfg_* inputs, zero all counters, clear ov
clr0  in  1  synchronous clear of cnt0
clr1  in  1  synchronous clear of cnt1
clr2  in  1  synchronous clear of cnt2
en0  in  1  increment cnt0
en1  in  1  increment cnt1
en2  in  1  increment cnt2
ld  in  1  window complete: advance window base and job counter
cfg_lim0  in  CNT_W  cnt0 terminal count (number of values)
cfg_lim1  in  CNT_W  cnt1 terminal count
cfg_lim2  in  CNT_W  cnt2 terminal count
cfg_jobs  in  JOB_W  number of windows in the job
cfg_base  in  ADDR_W  buffer start address
cfg_row  in  ADDR_W  row pitch
cfg_stride  in  ADDR_W  window-to-window address step
cnt0  out  CNT_W  filter-element index
cnt1  out  CNT_W  row index within window
cnt2  out  CNT_W  column index within window
ov0  out  1  cnt0 at terminal
ov1  out  1  cnt1 at terminal
ov2  out  1  cnt2 at terminal
ov  out  1  job done, sticky
rd_addr  out  ADDR_W  current read address

Behaviour:
- Reset (async, rst=1):
  - All counters, win_base, jcnt and config registers are 0; ov=0.
  - With zero config, limits are treated as 1 (see below), so ov0=ov1=ov2=1 and rd_addr=0.
  - Reset mid-job abandons the job immediately. A clrW is required before the next job.
- Config latch: on a clk edge with clrW=1, all cfg_* are captured into internal registers. cfg_* are ignored at all other times.
- Effective limit Lk = (lim_k==0) ? 1 : lim_k. A zero limit behaves as 1, so the counter stays at 0 and ovk=1.
- Counter k update, in priority order:
  - clrW: cntk <= 0.
  - else clrk: cntk <= 0.
  - else enk: cntk <= (cntk==Lk-1) ? 0 : cntk+1.
  - else hold.
  - clr has priority over en in the same cycle. The controller asserts both on overflow, and the result must be 0.
- ovk = (cntk == Lk-1). This is combinational from the registered count and the latched limit, with no extra latency. The controller samples it in the same cycle.
- Counters are independent: chaining order (mode) is decided entirely by the controller's en/clr strobes. This block has no mode input.
- Window advance: on a clk edge with ld=1 and clrW=0:
  - win_base <= win_base + stride (mod 2^ADDR_W).
  - jcnt <= jcnt + 1 (saturating at cfg_jobs).
  - ld has no effect once ov=1.
- Done flag:
  - ov is registered and set on the edge where ld=1 takes jcnt from cfg_jobs-1 to cfg_jobs.
  - With cfg_jobs=0, ov is set on the edge after clrW.
  - ov stays 1 until clrW or rst.
  - clrW and ld in the same cycle: clrW wins, ld is ignored.
- Address: rd_addr = base + win_base + cnt1*row + cnt2, truncated to ADDR_W.
  - It is combinational from registers, so it is valid in the same cycle the counters change.
  - The cnt1*row product is ADDR_W wide and wraps; no overflow flag.
  - cnt0 does not enter the address; it indexes the filter memory externally via the cnt0 output.
- Simultaneous clrk/enk on different counters in one cycle are all applied independently.
- A job restart (clrW) while a job is in progress re-latches config and zeroes all state, the same as a fresh start.

Test Plan:
- Reset: rst=1 mid-count (cnt0=3, win_base=0x20) -> next observation shows cnt0..2=0, ov=0, rd_addr=0, ov0..2=1.
- Init and address: clrW with base=0x100, row=0x10, stride=2, lim0=3, lim1=2, lim2=2, jobs=4; then en2 once, en1 once -> rd_addr sequence 0x100, 0x101, 0x111.
- Wrap and priority:
  - cnt0=2 (L0=3), en0=1, clr0=0 -> cnt0=0, with ov0=1 in the preceding cycle.
  - Same with clr0=1 -> cnt0=0.
  - cnt0=1, en0=1, clr0=1 -> cnt0=0, not 2.
- Zero limit: lim2=0 -> ov2=1 constantly, cnt2 stays 0 under repeated en2.
- Done: jobs=4, four ld pulses -> win_base=8 and ov=1 after the 4th edge. A 5th ld leaves win_base=8. clrW then drops ov to 0.
- Edge case: jobs=0 -> ov=1 one edge after clrW. clrW together with ld -> win_base=0, jcnt=0.
